counter_capture: RTL and testbench

COUNTER_CAPTURE -- requirements
Module: counter_capture

---
 rtl/counter_capture.sv | 113 +++++++++++
 tb/tb_counter_capture.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/counter_capture.sv
// Samples a loadable 8-bit counter on request or on a periodic timer and queues
// {sample, delta, flags} records in a small FIFO for a ready/valid consumer.
module counter_capture #(
  parameter int unsigned PERIOD = 16,
  parameter int unsigned DEPTH  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] cnt_in,
  input  logic       cnt_wr,
  input  logic       cap_req,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_sample,
  output logic [7:0] out_delta,
  output logic [1:0] out_flags,
  output logic [7:0] ovf_cnt,
  output logic [4:0] level
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [TW-1:0] TimerLast = (PERIOD > 0) ? TW'(PERIOD - 1) : '0;
  localparam logic [4:0] LevelFull = 5'(DEPTH);

  typedef struct packed {
    logic [7:0] sample;
    logic [7:0] delta;
    logic [1:0] flags;
  } entry_t;

  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    prev_q, prev_d;
  logic          load_q, load_d;
  logic          first_q, first_d;
  logic [7:0]    ovf_q, ovf_d;
  logic [4:0]    level_q, level_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  entry_t        mem_q [DEPTH];

  logic   expire, trigger, full, pop, push, drop;
  entry_t new_entry, head;

  always_comb begin
    expire  = (PERIOD != 0) && (timer_q == TimerLast);
    trigger = cap_req | expire;
    full    = (level_q == LevelFull);
    pop     = (level_q != 5'd0) && out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    push    = trigger && (!full || pop);
    drop    = trigger && full && !pop;

    new_entry.sample = cnt_in;
    new_entry.delta  = first_q ? 8'h00 : (cnt_in - prev_q);
    new_entry.flags  = {load_q | cnt_wr, first_q};

    timer_d  = (trigger || PERIOD == 0) ? '0 : (timer_q + TW'(1));
    prev_d   = trigger ? cnt_in : prev_q;
    first_d  = trigger ? 1'b0 : first_q;
    load_d   = trigger ? 1'b0 : (load_q | cnt_wr);
    ovf_d    = (drop && ovf_q != 8'hFF) ? (ovf_q + 8'd1) : ovf_q;
    wr_ptr_d = push ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d = pop ? (rd_ptr_q + AW'(1)) : rd_ptr_q;

    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + 5'd1;
    end else if (pop && !push) begin
      level_d = level_q - 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      timer_q  <= '0;
      prev_q   <= 8'h00;
      load_q   <= 1'b0;
      first_q  <= 1'b1;
      ovf_q    <= 8'h00;
      level_q  <= 5'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      timer_q  <= timer_d;
      prev_q   <= prev_d;
      load_q   <= load_d;
      first_q  <= first_d;
      ovf_q    <= ovf_d;
      level_q  <= level_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (reset && push) begin
      mem_q[wr_ptr_q] <= new_entry;
    end
  end

  always_comb begin
    head       = mem_q[rd_ptr_q];
    out_valid  = (level_q != 5'd0);
    out_sample = out_valid ? head.sample : 8'h00;
    out_delta  = out_valid ? head.delta : 8'h00;
    out_flags  = out_valid ? head.flags : 2'b00;
    ovf_cnt    = ovf_q;
    level      = level_q;
  end

endmodule

// File: tb/tb_counter_capture.sv
// Directed bench: a vector table on a timer-less instance plus timed sequences
// on a PERIOD=16 instance.
module tb_counter_capture;

  logic       clk;
  logic       reset;
  logic [7:0] cnt_in;
  logic       cnt_wr;
  logic       cap_req;
  logic       out_ready;

  logic       a_valid, b_valid;
  logic [7:0] a_sample, b_sample, a_delta, b_delta, a_ovf, b_ovf;
  logic [1:0] a_flags, b_flags;
  logic [4:0] a_level, b_level;

  int checks = 0;
  int errors = 0;

  counter_capture #(.PERIOD(16), .DEPTH(4)) dut_a (
    .clk        (clk),
    .reset      (reset),
    .cnt_in     (cnt_in),
    .cnt_wr     (cnt_wr),
    .cap_req    (cap_req),
    .out_valid  (a_valid),
    .out_ready  (out_ready),
    .out_sample (a_sample),
    .out_delta  (a_delta),
    .out_flags  (a_flags),
    .ovf_cnt    (a_ovf),
    .level      (a_level)
  );

  counter_capture #(.PERIOD(0), .DEPTH(4)) dut_b (
    .clk        (clk),
    .reset      (reset),
    .cnt_in     (cnt_in),
    .cnt_wr     (cnt_wr),
    .cap_req    (cap_req),
    .out_valid  (b_valid),
    .out_ready  (out_ready),
    .out_sample (b_sample),
    .out_delta  (b_delta),
    .out_flags  (b_flags),
    .ovf_cnt    (b_ovf),
    .level      (b_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [7:0] cnt;
    logic       wr;
    logic       req;
    logic       rdy;
    logic       vld;
    logic [7:0] smp;
    logic [7:0] dlt;
    logic [1:0] flg;
    logic [7:0] ovf;
    logic [4:0] lvl;
  } vec_t;

  localparam int NVec = 36;
  vec_t vecs [NVec];

  function automatic vec_t mk(logic rst, logic [7:0] cnt, logic wr, logic req, logic rdy,
                              logic vld, logic [7:0] smp, logic [7:0] dlt, logic [1:0] flg,
                              logic [7:0] ovf, logic [4:0] lvl);
    vec_t v;
    v.rst = rst; v.cnt = cnt; v.wr = wr; v.req = req; v.rdy = rdy;
    v.vld = vld; v.smp = smp; v.dlt = dlt; v.flg = flg; v.ovf = ovf; v.lvl = lvl;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; cnt_in = 8'h00; cnt_wr = 1'b0; cap_req = 1'b0; out_ready = 1'b0;

    //           rst cnt   wr req rdy  vld smp    dlt    flg    ovf  lvl
    vecs[0]  = mk(0, 8'h00, 0, 0, 0,   0, 8'h00, 8'h00, 2'b00, 8'd0, 5'd0);
    vecs[1]  = mk(1, 8'h10, 0, 1, 0,   1, 8'h10, 8'h00, 2'b01, 8'd0, 5'd1);
    vecs[2]  = mk(1, 8'h18, 0, 1, 0,   1, 8'h10, 8'h00, 2'b01, 8'd0, 5'd2);
    vecs[3]  = mk(1, 8'hF8, 0, 1, 0,   1, 8'h10, 8'h00, 2'b01, 8'd0, 5'd3);
    vecs[4]  = mk(1, 8'h04, 0, 1, 0,   1, 8'h10, 8'h00, 2'b01, 8'd0, 5'd4);
    vecs[5]  = mk(1, 8'h30, 0, 1, 0,   1, 8'h10, 8'h00, 2'b01, 8'd1, 5'd4);
    vecs[6]  = mk(1, 8'h35, 1, 0, 0,   1, 8'h10, 8'h00, 2'b01, 8'd1, 5'd4);
    vecs[7]  = mk(1, 8'h40, 0, 1, 0,   1, 8'h10, 8'h00, 2'b01, 8'd2, 5'd4);
    vecs[8]  = mk(1, 8'h40, 0, 0, 1,   1, 8'h18, 8'h08, 2'b00, 8'd2, 5'd3);
    vecs[9]  = mk(1, 8'h40, 0, 0, 1,   1, 8'hF8, 8'hE0, 2'b00, 8'd2, 5'd2);
    vecs[10] = mk(1, 8'h40, 0, 0, 1,   1, 8'h04, 8'h0C, 2'b00, 8'd2, 5'd1);
    vecs[11] = mk(1, 8'h80, 1, 0, 0,   1, 8'h04, 8'h0C, 2'b00, 8'd2, 5'd1);
    vecs[12] = mk(1, 8'h83, 0, 1, 0,   1, 8'h04, 8'h0C, 2'b00, 8'd2, 5'd2);
    vecs[13] = mk(1, 8'h90, 0, 1, 1,   1, 8'h83, 8'h43, 2'b10, 8'd2, 5'd2);
    vecs[14] = mk(1, 8'h90, 0, 0, 1,   1, 8'h90, 8'h0D, 2'b00, 8'd2, 5'd1);
    vecs[15] = mk(1, 8'h90, 0, 0, 1,   0, 8'h00, 8'h00, 2'b00, 8'd2, 5'd0);
    vecs[16] = mk(1, 8'h90, 0, 0, 1,   0, 8'h00, 8'h00, 2'b00, 8'd2, 5'd0);
    vecs[17] = mk(1, 8'hA0, 1, 1, 1,   1, 8'hA0, 8'h10, 2'b10, 8'd2, 5'd1);
    vecs[18] = mk(1, 8'hA5, 0, 1, 0,   1, 8'hA0, 8'h10, 2'b10, 8'd2, 5'd2);
    vecs[19] = mk(1, 8'hB0, 0, 1, 0,   1, 8'hA0, 8'h10, 2'b10, 8'd2, 5'd3);
    vecs[20] = mk(1, 8'hB8, 0, 1, 0,   1, 8'hA0, 8'h10, 2'b10, 8'd2, 5'd4);
    vecs[21] = mk(1, 8'hC0, 0, 1, 1,   1, 8'hA5, 8'h05, 2'b00, 8'd2, 5'd4);
    vecs[22] = mk(1, 8'hC0, 0, 0, 1,   1, 8'hB0, 8'h0B, 2'b00, 8'd2, 5'd3);
    vecs[23] = mk(1, 8'hC0, 0, 0, 1,   1, 8'hB8, 8'h08, 2'b00, 8'd2, 5'd2);
    vecs[24] = mk(1, 8'hC0, 0, 0, 1,   1, 8'hC0, 8'h08, 2'b00, 8'd2, 5'd1);
    vecs[25] = mk(1, 8'hC0, 0, 0, 1,   0, 8'h00, 8'h00, 2'b00, 8'd2, 5'd0);
    vecs[26] = mk(1, 8'h01, 0, 1, 0,   1, 8'h01, 8'h41, 2'b00, 8'd2, 5'd1);
    vecs[27] = mk(1, 8'h02, 0, 1, 0,   1, 8'h01, 8'h41, 2'b00, 8'd2, 5'd2);
    vecs[28] = mk(1, 8'h03, 0, 1, 0,   1, 8'h01, 8'h41, 2'b00, 8'd2, 5'd3);
    vecs[29] = mk(1, 8'h04, 0, 1, 0,   1, 8'h01, 8'h41, 2'b00, 8'd2, 5'd4);
    vecs[30] = mk(1, 8'h05, 0, 1, 0,   1, 8'h01, 8'h41, 2'b00, 8'd3, 5'd4);
    vecs[31] = mk(1, 8'h06, 0, 1, 0,   1, 8'h01, 8'h41, 2'b00, 8'd4, 5'd4);
    vecs[32] = mk(1, 8'h07, 0, 1, 0,   1, 8'h01, 8'h41, 2'b00, 8'd5, 5'd4);
    vecs[33] = mk(1, 8'h07, 0, 0, 1,   1, 8'h02, 8'h01, 2'b00, 8'd5, 5'd3);
    vecs[34] = mk(0, 8'h55, 0, 1, 1,   0, 8'h00, 8'h00, 2'b00, 8'd0, 5'd0);
    vecs[35] = mk(1, 8'h60, 0, 1, 0,   1, 8'h60, 8'h00, 2'b01, 8'd0, 5'd1);

    for (int i = 0; i < NVec; i++) begin
      reset = vecs[i].rst; cnt_in = vecs[i].cnt; cnt_wr = vecs[i].wr;
      cap_req = vecs[i].req; out_ready = vecs[i].rdy;
      step();
      chk($sformatf("row%0d valid", i), {7'd0, b_valid}, {7'd0, vecs[i].vld});
      chk($sformatf("row%0d sample", i), b_sample, vecs[i].smp);
      chk($sformatf("row%0d delta", i), b_delta, vecs[i].dlt);
      chk($sformatf("row%0d flags", i), {6'd0, b_flags}, {6'd0, vecs[i].flg});
      chk($sformatf("row%0d ovf", i), b_ovf, vecs[i].ovf);
      chk($sformatf("row%0d level", i), {3'd0, b_level}, {3'd0, vecs[i].lvl});
    end

    // Auto-sample timing: counter ramps from 0x10 at the first edge out of reset.
    reset = 1'b0; cap_req = 1'b0; cnt_wr = 1'b0; out_ready = 1'b0;
    step();
    for (int k = 1; k <= 32; k++) begin
      reset = 1'b1;
      cnt_in = 8'(8'h10 + k - 1);
      step();
      chk($sformatf("auto k%0d level", k), {3'd0, a_level},
          (k >= 32) ? 8'd2 : ((k >= 16) ? 8'd1 : 8'd0));
      if (k == 16) begin
        chk("auto first valid", {7'd0, a_valid}, 8'd1);
        chk("auto first sample", a_sample, 8'h1F);
        chk("auto first delta", a_delta, 8'h00);
        chk("auto first flags", {6'd0, a_flags}, 8'h01);
      end
    end
    out_ready = 1'b1;
    cnt_in = 8'h30;
    step();
    chk("auto second sample", a_sample, 8'h2F);
    chk("auto second delta", a_delta, 8'h10);
    chk("auto second flags", {6'd0, a_flags}, 8'h00);
    chk("auto after pop level", {3'd0, a_level}, 8'd1);

    // Coincident request and expiry, then request restarting the timer.
    reset = 1'b0; out_ready = 1'b0; cnt_in = 8'h22;
    step();
    for (int k = 1; k <= 56; k++) begin
      reset = 1'b1;
      cap_req = (k == 16 || k == 40);
      step();
      chk($sformatf("timer k%0d level", k), {3'd0, a_level},
          (k >= 56) ? 8'd4 : (k >= 40) ? 8'd3 : (k >= 32) ? 8'd2 : (k >= 16) ? 8'd1 : 8'd0);
    end
    cap_req = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
